neuron_activation: RTL

//  Downstream stage of the 400-input MAC. Captures each finished 16-bit dot product,

---
 rtl/nn_fixed_pkg.sv | 36 +++
 rtl/sigmoid_pwl.sv | 45 ++++
 rtl/neuron_activation.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/nn_fixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_fixed_pkg
//  Description : Shared constants for the neuron activation stage.
//                Holds the FSM state encodings, the Q8.8 breakpoints of the
//                piecewise-linear sigmoid, the segment offsets and ONE_Q88.
//                The sigmoid segments are:
//                  |x| >= 5.0    -> 1.0
//                  |x| >= 2.375  -> |x|/32 + 216/256
//                  |x| >= 1.0    -> |x|/8  + 160/256
//                  otherwise     -> |x|/4  + 128/256
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_fixed_pkg;

  // FSM state encodings
  localparam int                 STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_SUM  = 3'd1;
  localparam logic [STATE_W-1:0] ST_MAG  = 3'd2;
  localparam logic [STATE_W-1:0] ST_PWL  = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD = 3'd4;

  // Q8.8 magnitude breakpoints of the sigmoid segments
  localparam logic [15:0] THR_1P0   = 16'd256;   // 1.0
  localparam logic [15:0] THR_2P375 = 16'd608;   // 2.375
  localparam logic [15:0] THR_5P0   = 16'd1280;  // 5.0

  // Segment offsets in Q0.8 (one extra bit so 1.0 is representable)
  localparam logic [8:0] OFS_LOW  = 9'd128;
  localparam logic [8:0] OFS_MID  = 9'd160;
  localparam logic [8:0] OFS_HIGH = 9'd216;
  localparam logic [8:0] ONE_Q88  = 9'd256;

endpackage : nn_fixed_pkg
`default_nettype wire

// File: rtl/sigmoid_pwl.sv
`default_nettype none
// ============================================================================
//  Module      : sigmoid_pwl
//  Description : Purely combinational piecewise-linear sigmoid.
//                Maps a sign bit and a 16-bit unsigned Q8.8 magnitude to an
//                unsigned Q0.8 activation, with 1.0 clipped to 255.
//  Ports       : sign    in  1   1 = negative pre-activation
//                mag     in  16  |x| in Q8.8 (0x8000 means 128.0)
//                act_out out 8   sigmoid(x) in Q0.8
//  Revision    : 1.0 - initial release
// ============================================================================
module sigmoid_pwl
  import nn_fixed_pkg::*;
(
  input  logic        sign,
  input  logic [15:0] mag,
  output logic [7:0]  act_out
);

  logic [8:0] y_pos;
  logic [8:0] y;

  // The shifted terms are bounded by the segment limits (39, 75, 63), so
  // narrowing them to 9 bits never discards set bits.
  always_comb begin
    y_pos = ONE_Q88;
    if (mag >= THR_5P0) begin
      y_pos = ONE_Q88;
    end else if (mag >= THR_2P375) begin
      y_pos = 9'(mag >> 5) + OFS_HIGH;
    end else if (mag >= THR_1P0) begin
      y_pos = 9'(mag >> 3) + OFS_MID;
    end else begin
      y_pos = 9'(mag >> 2) + OFS_LOW;
    end
  end

  // Sigmoid symmetry: s(-x) = 1 - s(x).
  assign y = sign ? (ONE_Q88 - y_pos) : y_pos;

  // y never exceeds 256, so bit 8 alone marks the value that must clip.
  assign act_out = y[8] ? 8'hFF : y[7:0];

endmodule : sigmoid_pwl
`default_nettype wire

// File: rtl/neuron_activation.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_activation
//  Description : Downstream stage of the 400-input MAC. Captures each finished
//                Q8.8 dot product on the rising edge of mac_done, optionally
//                adds a bias, saturates to 16 bits, applies the PWL sigmoid
//                and presents one 8-bit activation over valid/ready. Counts
//                neurons per layer and pulses layer_done on the last one.
//  Config      : ACT_BIAS_EN - when defined the bias port is added to the MAC
//                result; otherwise bias is ignored.
//  Ports       : clk        in  1      clock, rising edge
//                reset      in  1      synchronous active-high reset
//                mac_result in  16     signed Q8.8 accumulator
//                mac_done   in  1      level done from MAC
//                bias       in  16     signed Q8.8 bias (ACT_BIAS_EN only)
//                out_ready  in  1      consumer ready
//                act_out    out 8      unsigned Q0.8 activation
//                act_valid  out 1      act_out valid, held until accepted
//                neuron_idx out IDX_W  current / next neuron index
//                layer_done out 1      pulse after last neuron accepted
//                sat_flag   out 1      sticky saturation flag
//                overrun    out 1      sticky dropped-start flag
//                busy       out 1      FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_activation
  import nn_fixed_pkg::*;
#(
  parameter int NUM_NEURONS = 25,
  parameter int IDX_W       = 5    // 2**IDX_W must cover NUM_NEURONS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      mac_result,
  input  logic             mac_done,
  input  logic [15:0]      bias,
  input  logic             out_ready,
  output logic [7:0]       act_out,
  output logic             act_valid,
  output logic [IDX_W-1:0] neuron_idx,
  output logic             layer_done,
  output logic             sat_flag,
  output logic             overrun,
  output logic             busy
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               mac_done_q;
  logic               start;
  logic               accept;
  logic [16:0]        sum_in;
  logic [16:0]        sum17;
  logic               sat_hi;
  logic               sat_lo;
  logic [15:0]        sat16;
  logic [15:0]        mag_in;
  logic               sign_q;
  logic [15:0]        mag_q;
  logic [7:0]         pwl_act;

  assign start  = mac_done & ~mac_done_q;
  assign accept = (state == ST_HOLD) & out_ready;

`ifdef ACT_BIAS_EN
  assign sum_in = {mac_result[15], mac_result} + {bias[15], bias};
`else
  logic unused_bias;
  assign unused_bias = ^bias;
  assign sum_in      = {mac_result[15], mac_result};
`endif

  // The 17-bit sum leaves the 16-bit range exactly when bits 16 and 15
  // disagree; bit 16 is the true sign.
  assign sat_hi = ~sum17[16] &  sum17[15];
  assign sat_lo =  sum17[16] & ~sum17[15];

  always_comb begin
    sat16 = sum17[15:0];
    if (sat_hi) begin
      sat16 = 16'h7FFF;
    end else if (sat_lo) begin
      sat16 = 16'h8000;
    end
  end

  // 0x8000 negates to itself; read as unsigned that is the wanted 32768.
  assign mag_in = sat16[15] ? (~sat16 + 16'd1) : sat16;

  sigmoid_pwl u_sigmoid_pwl (
    .sign    (sign_q),
    .mag     (mag_q),
    .act_out (pwl_act)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_SUM;
      ST_SUM:  state_nxt = ST_MAG;
      ST_MAG:  state_nxt = ST_PWL;
      ST_PWL:  state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    act_valid = (state == ST_HOLD);
    busy      = (state != ST_IDLE);
  end

  // Datapath, neuron counter and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_done_q <= 1'b0;
      sum17      <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      act_out    <= '0;
      neuron_idx <= '0;
      layer_done <= 1'b0;
      sat_flag   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mac_done_q <= mac_done;
      layer_done <= 1'b0;

      // A start outside IDLE is dropped and only recorded.
      if (start) begin
        if (state == ST_IDLE) begin
          sum17 <= sum_in;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (state == ST_SUM) begin
        sign_q <= sat16[15];
        mag_q  <= mag_in;
        if (sat_hi | sat_lo) begin
          sat_flag <= 1'b1;
        end
      end

      // act_out only changes here, so it is stable for the whole HOLD.
      if (state == ST_MAG) begin
        act_out <= pwl_act;
      end

      // layer_done is registered: it is high the cycle after the last
      // neuron of the layer is accepted.
      if (accept) begin
        if (neuron_idx == IDX_LAST) begin
          neuron_idx <= '0;
          layer_done <= 1'b1;
        end else begin
          neuron_idx <= neuron_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule : neuron_activation
`default_nettype wire
